// File: rtl/freq_pkg.sv
// Shared constants for the clock-division chain and the frequency meter state encoding.
// Consumed by freq_meter (optional period output enabled by FREQ_METER_PERIOD_EN).
package freq_pkg;

   localparam int unsigned CLK_HZ          = 12_000_000;
   localparam int unsigned DEF_CNT_W       = 24;
   localparam logic [27:0] DEF_GATE_CYCLES = 28'd12_000_000;

   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } state_t;

endpackage

// File: rtl/freq_meter_sync_edge.sv
// Multi-stage synchronizer for an asynchronous input followed by a rising-edge detector.
// The detector compares the synchronized level against its own one-cycle-delayed copy.
module sync_edge #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk_in,
   input  logic rst_n,
   input  logic d,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/freq_meter.sv
// Gate-window frequency meter: counts synchronized rising edges of sig_in over GATE_CYCLES clocks.
// Define FREQ_METER_PERIOD_EN to add an edge-to-edge period output.
module freq_meter
   import freq_pkg::*;
#(
   parameter logic [27:0] GATE_CYCLES = DEF_GATE_CYCLES,
   parameter int unsigned CNT_W       = DEF_CNT_W,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             en,
   input  logic             sig_in,
   output logic [CNT_W-1:0] count,
   output logic             valid,
   output logic             ovf
`ifdef FREQ_METER_PERIOD_EN
   ,
   output logic [CNT_W-1:0] period,
   output logic             period_valid
`endif
);

   localparam int unsigned GW = $clog2(GATE_CYCLES);
   localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 28'd1);
   localparam logic [CNT_W-1:0] EDGE_MAX  = '1;

   state_t           state_q, state_d;
   logic [GW-1:0]    gate_q, gate_d;
   logic [CNT_W-1:0] edge_q, edge_d, edgeNext;
   logic             sat_q, sat_d, satNext;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             valid_q, valid_d;
   logic             rise;

   sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync_edge (
      .clk_in(clk_in),
      .rst_n (rst_n),
      .d     (sig_in),
      .rise  (rise)
   );

   // Edge counter sticks at all-ones; an edge arriving there marks the window as saturated.
   always_comb begin
      edgeNext = edge_q;
      satNext  = sat_q;
      if (rise) begin
         if (edge_q == EDGE_MAX) begin
            satNext = 1'b1;
         end else begin
            edgeNext = edge_q + CNT_W'(1);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      gate_d  = gate_q;
      edge_d  = edge_q;
      sat_d   = sat_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            gate_d = '0;
            edge_d = '0;
            sat_d  = 1'b0;
            if (en) begin
               state_d = COUNT;
            end
         end
         COUNT: begin
            // The terminal cycle always reports, even if en drops on that same cycle.
            if (gate_q == GATE_LAST) begin
               count_d = edgeNext;
               ovf_d   = satNext;
               valid_d = 1'b1;
               gate_d  = '0;
               edge_d  = '0;
               sat_d   = 1'b0;
               if (!en) begin
                  state_d = IDLE;
               end
            end else if (!en) begin
               state_d = IDLE;
               gate_d  = '0;
               edge_d  = '0;
               sat_d   = 1'b0;
            end else begin
               gate_d = gate_q + GW'(1);
               edge_d = edgeNext;
               sat_d  = satNext;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gate_q  <= '0;
         edge_q  <= '0;
         sat_q   <= 1'b0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         gate_q  <= gate_d;
         edge_q  <= edge_d;
         sat_q   <= sat_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         valid_q <= valid_d;
      end
   end

   assign count = count_q;
   assign valid = valid_q;
   assign ovf   = ovf_q;

`ifdef FREQ_METER_PERIOD_EN
   logic [CNT_W-1:0] perCnt_q, perCnt_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic             armed_q, armed_d;
   logic             perValid_q, perValid_d;

   // The first edge after enabling only arms; each later edge reports the cycles since the previous one.
   always_comb begin
      perCnt_d   = perCnt_q;
      period_d   = period_q;
      armed_d    = armed_q;
      perValid_d = 1'b0;
      if (!en) begin
         armed_d  = 1'b0;
         perCnt_d = '0;
      end else if (rise) begin
         if (armed_q) begin
            period_d   = perCnt_q;
            perValid_d = 1'b1;
         end
         armed_d  = 1'b1;
         perCnt_d = CNT_W'(1);
      end else if (armed_q && (perCnt_q != EDGE_MAX)) begin
         perCnt_d = perCnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         perCnt_q   <= '0;
         period_q   <= '0;
         armed_q    <= 1'b0;
         perValid_q <= 1'b0;
      end else begin
         perCnt_q   <= perCnt_d;
         period_q   <= period_d;
         armed_q    <= armed_d;
         perValid_q <= perValid_d;
      end
   end

   assign period       = period_q;
   assign period_valid = perValid_q;
`endif

endmodule
